// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, combinational ROM read, 2-entry
// {pc,instr} buffer to decode, halt on zero word, redirect with flush.
// Ports: clk, rst_n, rom_addr/rom_data, redirect_valid/redirect_pc,
//        out_valid/out_ready/out_instr/out_pc, halted, misaligned_err.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted,
  output logic                  misaligned_err
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [1:0]            r_count;
  logic [ADDR_WIDTH-1:0] r_epc0;
  logic [ADDR_WIDTH-1:0] r_epc1;
  logic [DATA_WIDTH-1:0] r_ein0;
  logic [DATA_WIDTH-1:0] r_ein1;
  logic                  r_mis;

  logic w_pop;
  logic w_push;

  assign w_pop  = out_valid & out_ready;
  assign w_push = (r_state == RUN)
                & ((r_count < 2'd2) | w_pop)
                & ~redirect_valid;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_count <= 2'd0;
      r_epc0  <= '0;
      r_epc1  <= '0;
      r_ein0  <= '0;
      r_ein1  <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_mis <= redirect_valid & (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        r_count <= 2'd0;
        r_pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        r_state <= RUN;
      end else begin
        if (w_push) begin
          r_pc <= r_pc + ADDR_WIDTH'(4);
          if (rom_data == '0) r_state <= HALT;
        end
        unique case ({w_push, w_pop})
          2'b10: begin
            if (r_count == 2'd0) begin
              r_epc0 <= r_pc;
              r_ein0 <= rom_data;
            end else begin
              r_epc1 <= r_pc;
              r_ein1 <= rom_data;
            end
            r_count <= r_count + 2'd1;
          end
          2'b01: begin
            r_epc0  <= r_epc1;
            r_ein0  <= r_ein1;
            r_count <= r_count - 2'd1;
          end
          2'b11: begin
            if (r_count == 2'd2) begin
              r_epc0 <= r_epc1;
              r_ein0 <= r_ein1;
              r_epc1 <= r_pc;
              r_ein1 <= rom_data;
            end else begin
              r_epc0 <= r_pc;
              r_ein0 <= rom_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_addr       = r_pc;
  assign out_valid      = (r_count != 2'd0);
  assign out_instr      = r_ein0;
  assign out_pc         = r_epc0;
  assign halted         = (r_state == HALT);
  assign misaligned_err = r_mis;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit.
// One task per scenario; expected values are hand-computed.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
  logic        misaligned_err;

  int checks;
  int errors;
  logic rom_all_nz;

  instr_fetch_unit #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .halted(halted),
    .misaligned_err(misaligned_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rom_data = 32'h0;
    if (rom_all_nz) rom_data = {24'h100000, rom_addr};
    else begin
      case (rom_addr)
        8'h00: rom_data = 32'h00052503;
        8'h04: rom_data = 32'h0085a583;
        8'h08: rom_data = 32'h00a58633;
        default: rom_data = 32'h0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic v,
                         input logic [7:0] pc, input logic [31:0] ins);
    checks++;
    if (out_valid !== v || (v && (out_pc !== pc || out_instr !== ins))) begin
      errors++;
      $display("FAIL %s: got v=%b pc=%h ins=%h exp v=%b pc=%h ins=%h",
               nm, out_valid, out_pc, out_instr, v, pc, ins);
    end
  endtask

  task automatic test_reset();
    rom_all_nz = 1'b0;
    out_ready = 1'b1;
    do_reset();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, halted, misaligned_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 000",
               {out_valid, halted, misaligned_err});
    end
    checks++;
    if (out_pc !== 8'h00 || out_instr !== 32'h0 || rom_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals: got pc=%h ins=%h addr=%h exp 0 0 0",
               out_pc, out_instr, rom_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [7:0]  pcs [4];
    logic [31:0] ins [4];
    pcs = '{8'h00, 8'h04, 8'h08, 8'h0C};
    ins = '{32'h00052503, 32'h0085a583, 32'h00a58633, 32'h0};
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("seq%0d", i), 1'b1, pcs[i], ins[i]);
    end
    step();
    chk_out("seq_empty", 1'b0, 8'h00, 32'h0);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL seq_halted: got %b exp 1", halted);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 8'h00, 32'h00052503);
    end
    checks++;
    if (rom_addr !== 8'h08) begin
      errors++;
      $display("FAIL bp_pc: got %h exp 08", rom_addr);
    end
    out_ready = 1'b1;
    chk_out("bp_rel0", 1'b1, 8'h00, 32'h00052503);
    step();
    chk_out("bp_rel4", 1'b1, 8'h04, 32'h0085a583);
    step();
    chk_out("bp_rel8", 1'b1, 8'h08, 32'h00a58633);
    step();
    chk_out("bp_rel12", 1'b1, 8'h0C, 32'h0);
    step();
    chk_out("bp_done", 1'b0, 8'h00, 32'h0);
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    do_reset();
    repeat (5) step();
    out_ready = 1'b1;
    step();
    step();
    chk_out("rd_head8", 1'b1, 8'h08, 32'h00a58633);
    redirect_valid = 1'b1;
    redirect_pc = 8'h04;
    step();
    redirect_valid = 1'b0;
    chk_out("rd_flush", 1'b0, 8'h00, 32'h0);
    checks++;
    if (halted !== 1'b0 || misaligned_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_flags: got h=%b m=%b exp 0 0",
               halted, misaligned_err);
    end
    step();
    chk_out("rd_first", 1'b1, 8'h04, 32'h0085a583);
    step();
    chk_out("rd_next", 1'b1, 8'h08, 32'h00a58633);
  endtask

  task automatic test_misaligned();
    out_ready = 1'b1;
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h0A;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (misaligned_err !== 1'b1 || rom_addr !== 8'h08) begin
      errors++;
      $display("FAIL mis_pulse: got m=%b addr=%h exp 1 08",
               misaligned_err, rom_addr);
    end
    step();
    checks++;
    if (misaligned_err !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear: got %b exp 0", misaligned_err);
    end
    chk_out("mis_out", 1'b1, 8'h08, 32'h00a58633);
  endtask

  task automatic test_halt_restart();
    out_ready = 1'b1;
    do_reset();
    repeat (6) step();
    checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 8'h10) begin
      errors++;
      $display("FAIL hr_halted: got h=%b v=%b addr=%h exp 1 0 10",
               halted, out_valid, rom_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h00;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL hr_run: got %b exp 0", halted);
    end
    step();
    chk_out("hr_first", 1'b1, 8'h00, 32'h00052503);
  endtask

  task automatic test_wrap();
    rom_all_nz = 1'b1;
    out_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk_out("wrap_fc", 1'b1, 8'hFC, 32'h100000FC);
    step();
    chk_out("wrap_00", 1'b1, 8'h00, 32'h10000000);
    step();
    chk_out("wrap_04", 1'b1, 8'h04, 32'h10000004);
    rom_all_nz = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    rom_all_nz = 1'b0;
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_halt_restart();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
